mult_div_unit_16bit: RTL
========================

Name: mult_div_unit_16bit

Overview:
- Iterative 16-bit multiply/divide unit in the EX stage, with HI/LO result registers.
- Its `result` output drives input `in2` of the EX-stage 3:1 write-back/ALU-result select mux. Input `in0` is the ALU result and `in1` is the memory data.
- The pipeline controller stalls on `busy` and releases when `done` pulses.
- Covers MULT, MULTU, DIV and DIVU, plus MFHI/MFLO reads through `res_sel`.

Parameters:
- `DATA_W`, default 16: operand and HI/LO register width.
- `CNT_W`, default 5: iteration counter width. Must satisfy 2^`CNT_W` > `DATA_W`.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: request a new operation; sampled only in IDLE.
- `op`, input, 2: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- `rs`, input, `DATA_W`: multiplicand or dividend.
- `rt`, input, `DATA_W`: multiplier or divisor.
- `res_sel`, input, 1: 0 selects LO onto `result`, 1 selects HI.
- `busy`, output, 1: high while an operation is in flight.
- `done`, output, 1: one-cycle pulse when HI/LO have been updated.
- `dbz`, output, 1: divide-by-zero flag; pulses together with `done`.
- `hi`, output, `DATA_W`: HI register.
- `lo`, output, `DATA_W`: LO register.
- `result`, output, `DATA_W`: combinational mux of `res_sel ? hi : lo`; feeds `in2` of the 3:1 mux.

Behaviour:
- Reset
  - Asynchronous, active-low.
  - Forces state=IDLE, counter=0, `busy`=0, `done`=0, `dbz`=0, `hi`=0, `lo`=0, and clears all internal datapath registers.
  - Reset asserted mid-operation aborts it: no `done`, HI/LO = 0.
- State machine: IDLE -> CALC -> FINISH -> IDLE.
- IDLE
  - If `start`=1 at edge E0: latch `op`, take magnitudes of `rs`/`rt` when `op`[0]=1, record the operand signs, clear the accumulator and counter, go to CALC.
  - At E0, `busy` rises.
- CALC
  - One iteration per edge, E1..E16, counter 0..15.
  - Multiply: shift-add; a 2·`DATA_W` accumulator adds the multiplicand when the current multiplier LSB is 1, then shifts right.
  - Divide: restoring; shift the {remainder, quotient} pair left; if the trial subtraction of the divisor is ≥0, keep it and set the quotient LSB.
  - When the counter reaches 15 (edge E16), go to FINISH.
- FINISH (edge E17)
  - Signed multiply: negate the 32-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write `hi` = product[31:16] / remainder and `lo` = product[15:0] / quotient.
  - Set `done`=1 and `busy`=0, then go to IDLE.
- Timing
  - Fixed latency: `done` is high in the cycle following E17, i.e. 17 cycles after the start-sampling edge.
  - `done` and `dbz` are cleared on the next edge.
- Start collisions
  - `start` while `busy`=1 is ignored; operands and `op` are not re-latched.
  - `start` in the same cycle `done` is high (state IDLE) is accepted; back-to-back operations have zero bubble.
- Divide by zero (`rt`=0, DIV or DIVU)
  - Takes full latency.
  - Result: `hi`=`rs` (original, signed value), `lo`=16'hFFFF, `dbz`=1 with `done`.
- Overflow
  - DIV 0x8000 / 0xFFFF yields `lo`=16'h8000, `hi`=0. No trap.
- HI/LO hold their values until the next FINISH or reset. `result` follows `res_sel` combinationally at all times, including while busy (it shows the old value).
- Arithmetic
  - All magnitudes are unsigned `DATA_W`; |0x8000| = 0x8000.
  - Negation is two's complement, truncated to the field width.

Decomposition:
- Shared package `mips16_pkg`:
  - `op` encodings (`MDU_MULTU`, `MDU_MULT`, `MDU_DIVU`, `MDU_DIV`);
  - state encoding (IDLE, CALC, FINISH);
  - `MDU_ITER` = 16.
- No sub-module is required. The magnitude/negate logic stays inline as a function in the package.

Test Plan:
- Reset during CALC: MULTU 3×4, deassert `rst_n` at cycle 8 -> `busy`=0, `hi`=`lo`=0, no `done`. Start again -> normal completion.
- MULTU 0xFFFF×0xFFFF -> `done` 17 cycles after the start edge; `hi`=0xFFFE, `lo`=0x0001. With `res_sel`=1, `result`=0xFFFE.
- MULT 0xFFFD (−3) × 0x0005 -> `hi`=0xFFFF, `lo`=0xFFF1.
- DIVU 100/7 -> `lo`=0x000E, `hi`=0x0002.
- DIV 0xFFF9 (−7) / 0x0002 -> `lo`=0xFFFD, `hi`=0xFFFF.
- DIV 0x8000/0xFFFF -> `lo`=0x8000, `hi`=0x0000.
- DIVU 0x1234/0 -> `dbz`=1 with `done`; `hi`=0x1234, `lo`=0xFFFF.
- `start` pulsed at cycle 5 of a busy MULTU -> ignored: exactly one `done` and the original result.
- `start` asserted on the `done` cycle -> second `done` exactly 17 cycles after that start edge.

Source files
------------

// File: rtl/mips16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips16_pkg
// Description : Shared encodings and helpers for the MIPS16 EX-stage
//               multiply/divide unit (op codes, FSM states, negate helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package mips16_pkg;

  // Multiply/divide operation encodings carried on the op input
  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  // Number of shift-add / restoring iterations per operation
  localparam int MDU_ITER = 16;

  // Operand width the helper functions are built for
  localparam int MDU_W = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } mdu_state_e;

  // Conditional two's-complement negate of an operand-width value.
  // Also serves as magnitude when en is the operand's sign bit;
  // |0x8000| stays 0x8000, which is correct as an unsigned magnitude.
  function automatic logic [MDU_W-1:0] mdu_cneg(input logic [MDU_W-1:0] v,
                                                input logic             en);
    return en ? (~v + MDU_W'(1)) : v;
  endfunction

  // Conditional two's-complement negate of a double-width product
  function automatic logic [2*MDU_W-1:0] mdu_cneg_wide(input logic [2*MDU_W-1:0] v,
                                                       input logic               en);
    return en ? (~v + (2*MDU_W)'(1)) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_16bit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_16bit
// Description : Iterative 16-bit multiply/divide unit with HI/LO registers.
//               MULT/MULTU use shift-add, DIV/DIVU use restoring division.
//               Fixed latency: done pulses 17 cycles after the start edge.
//               result (= res_sel ? hi : lo) feeds in2 of the EX result mux.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit_16bit
  import mips16_pkg::*;
#(
  parameter int DATA_W = 16,  // must equal MDU_W of the package helpers
  parameter int CNT_W  = 5    // 2**CNT_W must exceed DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic              res_sel,
  output logic              busy,
  output logic              done,
  output logic              dbz,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] result
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  mdu_state_e            r_state;
  mdu_state_e            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_is_div;
  logic                  r_sign_a;     // dividend / multiplicand negative (signed ops only)
  logic                  r_sign_b;     // divisor / multiplier negative (signed ops only)
  logic                  r_dbz_pend;   // divisor was zero on a divide
  logic [DATA_W-1:0]     r_mcand;      // multiplicand magnitude, or divisor magnitude
  logic [DATA_W-1:0]     r_mplier;     // multiplier magnitude, shifted right each step
  logic [2*DATA_W-1:0]   r_acc;        // product accumulator, or {remainder, quotient}

  // --------------------------------------------------------------------------
  // Operand conditioning at start
  // --------------------------------------------------------------------------
  logic              w_is_div;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [DATA_W-1:0] w_rs_mag;
  logic [DATA_W-1:0] w_rt_mag;

  assign w_is_div = (op == MDU_DIVU) || (op == MDU_DIV);
  assign w_sign_a = op[0] & rs[DATA_W-1];
  assign w_sign_b = op[0] & rt[DATA_W-1];
  assign w_rs_mag = mdu_cneg(rs, w_sign_a);
  assign w_rt_mag = mdu_cneg(rt, w_sign_b);

  // --------------------------------------------------------------------------
  // One multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the carry-extended accumulator right.
  // --------------------------------------------------------------------------
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                    + (r_mplier[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

  // --------------------------------------------------------------------------
  // One restoring-divide step: shift {rem, quot} left, trial-subtract the
  // divisor from the widened remainder, keep it when no borrow occurs.
  // The remainder is always below the divisor, so a non-negative trial
  // result fits in DATA_W bits and the top bit acts as the borrow flag.
  // --------------------------------------------------------------------------
  logic [2*DATA_W:0]   w_div_pair;
  logic [DATA_W:0]     w_div_trial;
  logic [2*DATA_W-1:0] w_div_next;

  assign w_div_pair  = {r_acc, 1'b0};
  assign w_div_trial = w_div_pair[2*DATA_W:DATA_W] - {1'b0, r_mcand};
  assign w_div_next  = w_div_trial[DATA_W]
                     ? w_div_pair[2*DATA_W-1:0]
                     : {w_div_trial[DATA_W-1:0], w_div_pair[DATA_W-1:1], 1'b1};

  // --------------------------------------------------------------------------
  // Sign fix-up applied in FINISH
  // --------------------------------------------------------------------------
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;

  assign w_prod = mdu_cneg_wide(r_acc, r_sign_a ^ r_sign_b);
  assign w_quot = mdu_cneg(r_acc[DATA_W-1:0], r_sign_a ^ r_sign_b);
  assign w_rem  = mdu_cneg(r_acc[2*DATA_W-1:DATA_W], r_sign_a);

  // Read port for MFHI/MFLO; shows the held value even while busy
  assign result = res_sel ? hi : lo;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> CALC -> FINISH -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_cnt == CNT_W'(MDU_ITER - 1)) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath, iteration counter and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dbz        <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt      <= '0;
            r_is_div   <= w_is_div;
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
            r_dbz_pend <= w_is_div && (rt == '0);
            r_mcand    <= w_is_div ? w_rt_mag : w_rs_mag;
            r_mplier   <= w_rt_mag;
            // Divide seeds the quotient half with the dividend; multiply
            // starts from an empty accumulator.
            r_acc      <= w_is_div ? {{DATA_W{1'b0}}, w_rs_mag} : '0;
            busy       <= 1'b1;
          end
        end
        CALC: begin
          r_acc    <= r_is_div ? w_div_next : w_mul_next;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        FINISH: begin
          if (r_is_div) begin
            // A zero divisor leaves the dividend magnitude in the remainder,
            // so the sign fix-up restores the original rs for hi.
            hi <= w_rem;
            lo <= r_dbz_pend ? {DATA_W{1'b1}} : w_quot;
          end else begin
            hi <= w_prod[2*DATA_W-1:DATA_W];
            lo <= w_prod[DATA_W-1:0];
          end
          dbz  <= r_dbz_pend;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
